// File: rtl/ymf_write_queue_if.sv
// Write-side bus between the CoCo decode and the YMF write queue, plus the YMF pins it drives.
// The master drives CPU write strobes and the overflow clear; the slave is the queue itself.
interface ymf_write_queue_if;
    logic       wr_stb;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       ovf_clr;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;
    logic [1:0] ymf_addr;
    logic [7:0] ymf_data;
    logic       ymf_oe;
    logic       _ymf_cs;
    logic       _ymf_wr;

    modport master (
        output wr_stb, wr_addr, wr_data, ovf_clr,
        input  full, empty, busy, overflow, ymf_addr, ymf_data, ymf_oe, _ymf_cs, _ymf_wr
    );

    modport slave (
        input  wr_stb, wr_addr, wr_data, ovf_clr,
        output full, empty, busy, overflow, ymf_addr, ymf_data, ymf_oe, _ymf_cs, _ymf_wr
    );
endinterface

// File: rtl/ymf_write_queue.sv
// Posted-write FIFO for the YMF register window, drained by a sequencer that shapes
// chip-select/write pulses and enforces the chip's recovery time after each write.
module ymf_write_queue #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WR_PULSE   = 3,
    parameter int ADDR_WAIT  = 12,
    parameter int DATA_WAIT  = 84
) (
    input logic               clock_i,
    input logic               _reset_i,
    ymf_write_queue_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, RECOVER} state_t;

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [7:0]          PULSE_LOAD = 8'(WR_PULSE - 1);
    localparam logic [7:0]          ADDR_LOAD  = 8'(ADDR_WAIT - 1);
    localparam logic [7:0]          DATA_LOAD  = 8'(DATA_WAIT - 1);

    logic [9:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [7:0]            timer_q, timer_d;
    logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
    logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [1:0]            ymfAddr_q, ymfAddr_d;
    logic [7:0]            ymfData_q, ymfData_d;
    logic                  oe_q, oe_d;
    logic                  csN_q, csN_d;
    logic                  wrN_q, wrN_d;
    logic                  push;
    logic                  pop;
    logic                  fifoEmpty;

    assign fifoEmpty = (count_q == '0);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        ymfAddr_d  = ymfAddr_q;
        ymfData_d  = ymfData_q;
        pop        = 1'b0;

        // One down-counter serves both the write pulse and the recovery wait.
        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = PULSE;
                timer_d = PULSE_LOAD;
            end
            PULSE: begin
                if (timer_q == 8'd0) state_d = HOLD;
                else                 timer_d = timer_q - 8'd1;
            end
            HOLD: begin
                state_d = RECOVER;
                timer_d = ymfAddr_q[0] ? DATA_LOAD : ADDR_LOAD;
            end
            RECOVER: begin
                if (timer_q != 8'd0) begin
                    timer_d = timer_q - 8'd1;
                end else if (!fifoEmpty) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A full FIFO still accepts a write when the head leaves in the same cycle.
        push = bus.wr_stb && ((count_q != DEPTH_CNT) || pop);

        if (pop) begin
            ymfAddr_d = mem[rdPtr_q][9:8];
            ymfData_d = mem[rdPtr_q][7:0];
            rdPtr_d   = rdPtr_q + 1'b1;
        end
        if (push) wrPtr_d = wrPtr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (bus.wr_stb && !push) overflow_d = 1'b1;
        else if (bus.ovf_clr)    overflow_d = 1'b0;

        csN_d = !(state_d inside {SETUP, PULSE, HOLD});
        wrN_d = (state_d != PULSE);
        oe_d  = !csN_d;
    end

    always_ff @(posedge clock_i or negedge _reset_i) begin
        if (!_reset_i) begin
            state_q    <= IDLE;
            timer_q    <= 8'd0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ymfAddr_q  <= 2'd0;
            ymfData_q  <= 8'h00;
            oe_q       <= 1'b0;
            csN_q      <= 1'b1;
            wrN_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            ymfAddr_q  <= ymfAddr_d;
            ymfData_q  <= ymfData_d;
            oe_q       <= oe_d;
            csN_q      <= csN_d;
            wrN_q      <= wrN_d;
        end
    end

    // Storage is left unreset; the pointers and count alone define what is valid.
    always_ff @(posedge clock_i) begin
        if (push) mem[wrPtr_q] <= {bus.wr_addr, bus.wr_data};
    end

    assign bus.full     = (count_q == DEPTH_CNT);
    assign bus.empty    = fifoEmpty;
    assign bus.busy     = (state_q != IDLE);
    assign bus.overflow = overflow_q;
    assign bus.ymf_addr = ymfAddr_q;
    assign bus.ymf_data = ymfData_q;
    assign bus.ymf_oe   = oe_q;
    assign bus._ymf_cs  = csN_q;
    assign bus._ymf_wr  = wrN_q;

endmodule

// File: tb/tb_ymf_write_queue.sv
// Bench for ymf_write_queue: directed scenarios plus random traffic, every cycle compared
// against a timeline model that schedules each accepted write's bus cycle arithmetically.
module tb_ymf_write_queue;

    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int WR_PULSE   = 3;
    localparam int ADDR_WAIT  = 12;
    localparam int DATA_WAIT  = 84;

    // {full, empty, busy, overflow, ymf_addr, ymf_data, ymf_oe, _ymf_cs, _ymf_wr}
    localparam logic [16:0] RESET_VEC = {1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1};

    typedef struct {
        int         accT;
        int         popT;
        int         period;
        logic [1:0] a;
        logic [7:0] d;
    } write_t;

    logic clock    = 1'b0;
    logic clkRun   = 1'b0;
    logic _reset   = 1'b1;

    ymf_write_queue_if bus ();

    ymf_write_queue #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WR_PULSE   (WR_PULSE),
        .ADDR_WAIT  (ADDR_WAIT),
        .DATA_WAIT  (DATA_WAIT)
    ) dut (
        .clock_i  (clock),
        ._reset_i (_reset),
        .bus      (bus)
    );

    always #5 clock = clkRun ? ~clock : clock;

    write_t wq[$];
    int     csFalls[$];
    logic   modelOvf = 1'b0;
    logic   prevCs   = 1'b1;
    int     cyc      = 0;
    int     assertCount = 0;
    int     failCount   = 0;

    // Schedule: a write's bus cycle starts one edge after it is accepted, or when the
    // previous write's cycle (2 + pulse + its recovery) ends, whichever is later.
    task automatic modelEdge(input int t, input logic stb, input logic [1:0] a,
                             input logic [7:0] d, input logic clr);
        int     occ = 0;
        bit     popAt = 0;
        bit     accepted = 0;
        int     start;
        write_t w;
        foreach (wq[i]) begin
            if (wq[i].accT < t && wq[i].popT >= t) occ++;
            if (wq[i].popT == t) popAt = 1;
        end
        if (stb && (occ < DEPTH || popAt)) begin
            accepted = 1;
            start = t + 1;
            if (wq.size() > 0 && wq[wq.size()-1].popT + wq[wq.size()-1].period > start)
                start = wq[wq.size()-1].popT + wq[wq.size()-1].period;
            w.accT   = t;
            w.popT   = start;
            w.period = 2 + WR_PULSE + (a[0] ? DATA_WAIT : ADDR_WAIT);
            w.a      = a;
            w.d      = d;
            wq.push_back(w);
        end
        if (stb && !accepted) modelOvf = 1'b1;
        else if (clr)         modelOvf = 1'b0;
    endtask

    function automatic logic [16:0] expectedOutputs(input int t);
        int         cur = -1;
        int         pending = 0;
        int         k;
        logic       cs = 1'b1;
        logic       wr = 1'b1;
        logic       busyE = 1'b0;
        logic [1:0] a = 2'd0;
        logic [7:0] d = 8'h00;
        foreach (wq[i]) begin
            if (wq[i].popT <= t) cur = i;
            if (wq[i].accT <= t && wq[i].popT > t) pending++;
        end
        if (cur >= 0) begin
            k     = t - wq[cur].popT;
            a     = wq[cur].a;
            d     = wq[cur].d;
            cs    = !(k <= 1 + WR_PULSE);
            wr    = !(k >= 1 && k <= WR_PULSE);
            busyE = (k < wq[cur].period);
        end
        return {pending == DEPTH, pending == 0, busyE, modelOvf, a, d, !cs, cs, wr};
    endfunction

    function automatic logic [16:0] observedOutputs();
        return {bus.full, bus.empty, bus.busy, bus.overflow, bus.ymf_addr, bus.ymf_data,
                bus.ymf_oe, bus._ymf_cs, bus._ymf_wr};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock edge: model the sampled inputs, compare all outputs 1 time unit later.
    task automatic applyStimulus(input logic stb, input logic [1:0] a, input logic [7:0] d,
                                 input logic clr);
        bus.wr_stb  = stb;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.ovf_clr = clr;
        @(posedge clock);
        cyc++;
        modelEdge(cyc, stb, a, d, clr);
        #1;
        checkOutput($sformatf("outputs@%0d", cyc), 32'(observedOutputs()),
                    32'(expectedOutputs(cyc)));
        if (prevCs && !bus._ymf_cs) csFalls.push_back(cyc);
        prevCs = bus._ymf_cs;
        bus.wr_stb  = 1'b0;
        bus.ovf_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        int lastEnd = cyc;
        if (wq.size() > 0) lastEnd = wq[wq.size()-1].popT + wq[wq.size()-1].period;
        if (lastEnd > cyc) idle(lastEnd - cyc + 2);
        else               idle(2);
    endtask

    initial begin
        int nextPop;
        bus.wr_stb  = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 8'h00;
        bus.ovf_clr = 1'b0;

        // Reset with no clock running.
        #2 _reset = 1'b0;
        #1 checkOutput("resetNoClock", 32'(observedOutputs()), 32'(RESET_VEC));
        clkRun = 1'b1;
        repeat (3) @(negedge clock);
        _reset = 1'b1;
        idle(10);
        checkOutput("idleCsWr", 32'({bus._ymf_cs, bus._ymf_wr}), 32'(2'b11));

        // Single address-port write.
        applyStimulus(1'b1, 2'd0, 8'h20, 1'b0);
        drain();

        // Address, data, address back to back: cs fall spacing set by the earlier write.
        csFalls.delete();
        applyStimulus(1'b1, 2'd0, 8'h20, 1'b0);
        applyStimulus(1'b1, 2'd1, 8'h5A, 1'b0);
        applyStimulus(1'b1, 2'd0, 8'h30, 1'b0);
        drain();
        checkOutput("csFallCount", 32'(csFalls.size()), 32'd3);
        if (csFalls.size() == 3) begin
            checkOutput("gapAfterAddr", 32'(csFalls[1] - csFalls[0]), 32'd17);
            checkOutput("gapAfterData", 32'(csFalls[2] - csFalls[1]), 32'd89);
        end

        // Six strobes from empty: five accepted, the sixth dropped.
        csFalls.delete();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'(i), 8'(8'h40 + i), 1'b0);
        checkOutput("overflowSet", 32'(bus.overflow), 32'd1);
        checkOutput("fullAfterBurst", 32'(bus.full), 32'd1);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
        checkOutput("overflowCleared", 32'(bus.overflow), 32'd0);

        // Strobe into a full FIFO on the edge the head is popped.
        nextPop = 0;
        foreach (wq[i]) if (nextPop == 0 && wq[i].popT > cyc) nextPop = wq[i].popT;
        if (nextPop > cyc + 1) idle(nextPop - cyc - 1);
        applyStimulus(1'b1, 2'd1, 8'hC3, 1'b0);
        checkOutput("pushOnPopNoOvf", 32'(bus.overflow), 32'd0);
        checkOutput("pushOnPopFull", 32'(bus.full), 32'd1);
        drain();
        checkOutput("burstCycles", 32'(csFalls.size()), 32'd6);

        // Random traffic.
        for (int i = 0; i < 1500; i++)
            applyStimulus(($urandom_range(7) == 0), 2'($urandom_range(3)),
                          8'($urandom_range(255)), ($urandom_range(31) == 0));
        drain();

        // Reset in the middle of a write pulse with entries queued.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'(i), 8'(8'h90 + i), 1'b0);
        idle(1);
        checkOutput("inPulse", 32'(bus._ymf_wr), 32'd0);
        @(negedge clock);
        #2 _reset = 1'b0;
        #1 checkOutput("resetMidPulse", 32'(observedOutputs()), 32'(RESET_VEC));
        repeat (2) @(posedge clock);
        @(negedge clock);
        _reset = 1'b1;
        wq.delete();
        modelOvf = 1'b0;
        prevCs   = 1'b1;
        csFalls.delete();
        idle(150);
        checkOutput("noCyclesAfterReset", 32'(csFalls.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ymf_write_queue.md
# ymf_write_queue

Posted-write buffer and bus-cycle sequencer between the cartridge's CoCo-side bus decode and the YMF audio chip. CPU writes to the YMF window ($ff50-$ff53) arrive as single-cycle strobes and are queued in a small FIFO. A drain engine replays each write to the YMF with its required chip-select and write-pulse shape and the chip's minimum recovery time, so the 6809 can write back-to-back without polling the YMF busy status. Only the write path passes through this block; reads continue to reach the YMF on the direct path.

## Interface
- DEPTH_LOG2, 2: FIFO depth is 2**DEPTH_LOG2 entries.
- WR_PULSE, 3: `_ymf_wr` low time in cycles; must be at least 1.
- ADDR_WAIT, 12: recovery cycles after an address-port write (`addr[0]=0`); range 1-255.
- DATA_WAIT, 84: recovery cycles after a data-port write (`addr[0]=1`); range 1-255.
---
- clock  in  1  single system clock. All logic is rising-edge.
- _reset  in  1  asynchronous, active-low reset.
- wr_stb  in  1  one-cycle write request, synchronous to `clock`.
- wr_addr  in  2  YMF register-port select (CPU `address[1:0]`).
- wr_data  in  8  write data.
- full  out  1  FIFO holds 2**DEPTH_LOG2 entries.
- empty  out  1  FIFO holds 0 entries.
- busy  out  1  sequencer is not in IDLE.
- overflow  out  1  sticky flag: a write was dropped.
- ovf_clr  in  1  clears `overflow`.
- ymf_addr  out  2  YMF A1:A0.
- ymf_data  out  8  YMF D7:D0.
- ymf_oe  out  1  enables the board's data-bus driver toward the YMF.
- _ymf_cs  out  1  YMF chip select, active low.
- _ymf_wr  out  1  YMF write strobe, active low.

## Operation
- FIFO entries are 10 bits wide: {addr, data}. Read and write pointers are DEPTH_LOG2 bits wide and wrap modulo the depth. The entry count is DEPTH_LOG2+1 bits wide.
- Push happens when `wr_stb` is high and either the count is below the depth or a pop occurs in the same cycle. A `wr_stb` that is not pushed is dropped and sets `overflow`.
- `overflow` has a fixed priority: a set in the same cycle as `ovf_clr` wins over the clear.
- Pop happens on every transition into SETUP. On that edge the head entry is latched into `ymf_addr`/`ymf_data`, which stay stable until the next pop.
- The sequencer states and transitions are:
  - IDLE: when `empty` is low, pop and go to SETUP.
  - SETUP: lasts 1 cycle. `_ymf_cs`=0, `ymf_oe`=1, `_ymf_wr`=1. Goes to PULSE.
  - PULSE: lasts WR_PULSE cycles. `_ymf_wr`=0. Goes to HOLD.
  - HOLD: lasts 1 cycle. `_ymf_wr`=1, `_ymf_cs`=0. Goes to RECOVER.
  - RECOVER: lasts W cycles, where W is ADDR_WAIT if the latched `ymf_addr[0]`=0 and DATA_WAIT otherwise. `_ymf_cs`=1, `ymf_oe`=0. On exit, if the FIFO is not empty, pop and go directly to SETUP; otherwise go to IDLE.
- A single 8-bit down-counter times both PULSE and RECOVER.
- `_ymf_cs`, `_ymf_wr` and `ymf_oe` are registered outputs (decoded from the next state), so they are glitch-free.

## Timing
- Reset values:
  - `full`=0, `empty`=1, `busy`=0, `overflow`=0.
  - `ymf_addr`=0, `ymf_data`=0x00, `ymf_oe`=0, `_ymf_cs`=1, `_ymf_wr`=1.
  - Pointers and count are 0; state is IDLE.
- Reset asserted mid-operation flushes the FIFO and forces all outputs to their reset values immediately, without waiting for a clock.
- Latency into an empty, idle block: `wr_stb` sampled at edge N. `_ymf_cs`=0 after edge N+1. `_ymf_wr`=0 after edge N+2 for WR_PULSE cycles. `_ymf_cs`=1 after edge N+3+WR_PULSE.
- Period between successive `_ymf_cs` falling edges: 2+WR_PULSE+W cycles, where W is set by the earlier write.
- Because of the pop on the IDLE-to-SETUP edge, an empty idle FIFO never reports `full` from a single write.
- `full` and `empty` reflect the registered count. They update one edge after a push or pop.

## Test plan
- **Reset:** assert `_reset` low asynchronously with no clock running -> all outputs read their reset values. Release reset, then run 10 idle cycles -> `_ymf_cs` and `_ymf_wr` stay at 1.
- **Single write:** `wr_stb` with addr=0, data=0x20 at edge 0 -> `_ymf_cs` low during edges 1-6. `_ymf_wr` low during edges 2-5. `ymf_addr`=0 and `ymf_data`=0x20 are stable throughout. `busy` drops 12 cycles after `_ymf_cs` rises.
- **Address then data:** back-to-back strobes (0,0x20), then (1,0x5A) -> the second `_ymf_cs` fall comes 17 cycles after the first. A third write to addr 0 follows 89 cycles after the second.
- **Overflow:** 6 strobes on consecutive cycles, starting empty -> 5 writes are accepted, the 6th is dropped and `overflow`=1. Exactly 5 YMF cycles are issued, in order. Then pulse `ovf_clr` -> `overflow`=0.
- **Push when full with simultaneous pop:** fill to 4 entries, then strobe in the cycle RECOVER exits to SETUP -> the write is accepted, `overflow` stays 0, and `full` stays 1.
- **Reset mid-pulse:** assert `_reset` during PULSE with 3 entries queued -> `_ymf_wr` and `_ymf_cs` go to 1 immediately, `empty`=1, and no further YMF cycles occur after release.
